spi_burst_memory: RTL and testbench
===================================

SPI_BURST_MEMORY -- requirements
Module: spi_burst_memory

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default 7, address bits per transaction.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 8, bits per memory word.
REQ-003 The module SHALL have parameter DEPTH, default 2**ADDR_WIDTH, number of words; legal range 2..2**ADDR_WIDTH.
REQ-004 The module SHALL have parameter BURST, default 1, where 1 enables address auto-increment while CS stays low and 0 selects single-word transfers.
REQ-005 The module SHALL have port clk, input, 1 bit: the single system clock, rising edge.
REQ-006 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The module SHALL have port sclk, input, 1 bit: SPI serial clock, asynchronous to clk.
REQ-008 The module SHALL have port cs_pin, input, 1 bit: chip select, active low.
REQ-009 The module SHALL have port mosi_pin, input, 1 bit: serial data from the master.
REQ-010 The module SHALL have port miso_pin, output, 1 bit: serial read data to the master.
REQ-011 The module SHALL have port leds, output, 4 bits: status indicators.

Function
REQ-012 sclk, cs_pin and mosi_pin SHALL each pass through a 2-flop synchronizer; sclk edges SHALL be detected as 1-clk pulses, with a total latency of 3 clk cycles from the pin.
REQ-013 Correct operation SHALL require clk to be at least 8x the sclk frequency.
REQ-014 mosi SHALL be sampled on detected sclk rising edges; miso SHALL update on detected sclk falling edges; all transfers SHALL be MSB first.
REQ-015 The FSM SHALL have the states IDLE, ADDR, RW, WDATA, RDATA and HOLD.
REQ-016 A CS falling edge SHALL move the FSM IDLE->ADDR and clear the bit counter.
REQ-017 ADDR SHALL shift in ADDR_WIDTH bits and then go to RW.
REQ-018 RW SHALL sample one bit: 0 = write, going to WDATA; 1 = read, going to RDATA.
REQ-019 If the address is >= DEPTH, the address SHALL wrap modulo DEPTH.
REQ-020 In WDATA, on the DATA_WIDTH-th rising edge, mem[addr] SHALL be written in the next clk cycle.
  - With BURST=1: addr increments, wrapping DEPTH-1->0, and the FSM stays in WDATA.
  - With BURST=0: the FSM goes to HOLD.
REQ-021 On the rising edge that samples RW=1, the read shift register SHALL load mem[addr].
  - Each subsequent falling edge drives the next bit, MSB first.
REQ-022 After DATA_WIDTH bits have been shifted out in RDATA:
  - With BURST=1: addr increments (wrapping) and mem[new addr] loads on the last bit's rising edge, so the following falling edge drives the new MSB with no gap.
  - With BURST=0: the FSM goes to HOLD.
REQ-023 HOLD SHALL ignore sclk and mosi and SHALL drive miso_pin 0.
REQ-024 A CS rising edge in any state SHALL return the FSM to IDLE within 1 clk of detection; a partially received write word SHALL be discarded with memory unchanged.
REQ-025 miso_pin SHALL be 0 in IDLE, ADDR, RW, WDATA and HOLD.
REQ-026 leds[0] SHALL be 1 while the synchronized CS is low.
REQ-027 leds[1] SHALL be 1 in RDATA.
REQ-028 leds[2] SHALL be 1 in WDATA.
REQ-029 leds[3] SHALL be a sticky flag, set when a burst address wraps DEPTH-1->0 and cleared on the next CS falling edge.
REQ-030 A CS falling edge and a sclk rising edge detected in the same clk SHALL count that sclk edge as address bit 0.

Reset
REQ-031 While reset is high, the FSM SHALL be IDLE, all counters and shift registers 0, synchronizer flops 1 for cs and 0 for sclk and mosi, miso_pin 0 and leds 4'b0000.
REQ-032 Memory contents SHALL NOT be cleared by reset.
REQ-033 Reset asserted mid-transaction SHALL abort it without a memory write.
REQ-034 After reset release, the FSM SHALL wait for a fresh CS falling edge; if CS is already low at release, the FSM SHALL stay IDLE until CS goes high and then low again.

Verification
REQ-035 Defaults: write addr 7'h55, RW 0, data 8'hAA, then raise CS; a new read of 7'h55 -> miso returns 10101010; leds[2] is high during the write.
REQ-036 BURST=1: write at 7'h7E data 8'h11, 8'h22, 8'h33 in one CS frame -> mem[7E]=11, mem[7F]=22, mem[00]=33, leds[3]=1; burst read from 7'h7E returns the same three bytes contiguously.
REQ-037 Raise CS after 5 of 8 data bits of a write to 7'h10 (mem[10] preloaded 8'h5A) -> mem[10] remains 8'h5A and the FSM is IDLE.
REQ-038 BURST=0: write 8'h0F to 7'h20, then 8 more bits 8'hFF in the same frame -> mem[20]=8'h0F, mem[21] unchanged, miso_pin stays 0.
REQ-039 Assert reset after 4 read bits have been shifted out -> miso_pin and leds go to 0 asynchronously; a subsequent read of the same address returns the original data.
REQ-040 DEPTH=100: write to address 7'd105 -> the data lands at mem[5].

Source files
------------

// File: rtl/spi_burst_memory.sv
`timescale 1ns / 1ps
// SPI slave in front of an inferred word memory. A frame carries the address,
// one R/W bit, then data words; bursts auto-increment the address while CS is low.
module spi_burst_memory #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2 ** ADDR_WIDTH,
  parameter int BURST      = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       cs_pin,
  input  logic       mosi_pin,
  output logic       miso_pin,
  output logic [3:0] leds
);

  localparam int MAX_FIELD = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_WIDTH = $clog2(MAX_FIELD + 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [2:0] {IDLE, ADDR, RW, WDATA, RDATA, HOLD} state_t;

  state_t state_reg, state_next;

  logic [1:0] sclk_sync_reg, cs_sync_reg, mosi_sync_reg;
  logic       sclk_prev_reg, cs_prev_reg;
  logic [1:0] settle_reg;
  logic       armed_reg;

  logic [CNT_WIDTH-1:0]  bit_cnt_reg;
  logic [ADDR_WIDTH-1:0] addr_reg, wr_addr_reg, rd_addr;
  logic [DATA_WIDTH-1:0] wdata_reg, rd_shift_reg, wr_data_reg, rd_data_reg;
  logic                  miso_reg, wr_en_reg, wrap_reg;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_bit;
  logic last_addr_bit, last_data_bit, addr_at_end;
  logic [ADDR_WIDTH-1:0] addr_shift, addr_wrapped, addr_inc;
  logic [ADDR_WIDTH:0]   addr_full;
  logic [DATA_WIDTH-1:0] data_shift;

  // Two synchronizer stages plus one history flop for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync_reg <= 2'b00;
      cs_sync_reg   <= 2'b11;
      mosi_sync_reg <= 2'b00;
      sclk_prev_reg <= 1'b0;
      cs_prev_reg   <= 1'b1;
      settle_reg    <= 2'd0;
      armed_reg     <= 1'b0;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[0], sclk};
      cs_sync_reg   <= {cs_sync_reg[0], cs_pin};
      mosi_sync_reg <= {mosi_sync_reg[0], mosi_pin};
      sclk_prev_reg <= sclk_sync_reg[1];
      cs_prev_reg   <= cs_sync_reg[1];
      if (settle_reg != 2'd3) settle_reg <= settle_reg + 2'd1;
      // Only a CS that was genuinely seen high after reset may start a frame.
      if (settle_reg == 2'd3 && cs_sync_reg[1]) armed_reg <= 1'b1;
    end
  end

  assign sclk_rise = sclk_sync_reg[1] & ~sclk_prev_reg;
  assign sclk_fall = ~sclk_sync_reg[1] & sclk_prev_reg;
  assign cs_fall   = armed_reg & cs_prev_reg & ~cs_sync_reg[1];
  assign cs_rise   = cs_sync_reg[1] & ~cs_prev_reg;
  assign mosi_bit  = mosi_sync_reg[1];

  assign last_addr_bit = (bit_cnt_reg == CNT_WIDTH'(ADDR_WIDTH - 1));
  assign last_data_bit = (bit_cnt_reg == CNT_WIDTH'(DATA_WIDTH - 1));
  assign addr_at_end   = (addr_reg == LAST_ADDR);
  assign addr_inc      = addr_at_end ? '0 : addr_reg + 1'b1;
  assign addr_shift    = {addr_reg[ADDR_WIDTH-2:0], mosi_bit};
  assign addr_full     = {1'b0, addr_shift} % DEPTH_W;
  assign addr_wrapped  = addr_full[ADDR_WIDTH-1:0];
  assign data_shift    = {wdata_reg[DATA_WIDTH-2:0], mosi_bit};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (cs_rise) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (cs_fall) state_next = ADDR;
        ADDR:    if (sclk_rise && last_addr_bit) state_next = RW;
        RW:      if (sclk_rise) state_next = mosi_bit ? RDATA : WDATA;
        WDATA:   if (sclk_rise && last_data_bit && BURST == 0) state_next = HOLD;
        RDATA:   if (sclk_rise && last_data_bit && BURST == 0) state_next = HOLD;
        HOLD:    state_next = HOLD;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    miso_pin = (state_reg == RDATA) ? miso_reg : 1'b0;
    leds     = {wrap_reg, state_reg == WDATA, state_reg == RDATA, ~cs_sync_reg[1]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_reg  <= '0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      rd_shift_reg <= '0;
      miso_reg     <= 1'b0;
      wr_en_reg    <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
      wrap_reg     <= 1'b0;
    end else begin
      wr_en_reg <= 1'b0;
      if (state_reg == IDLE && cs_fall) begin
        wrap_reg    <= 1'b0;
        bit_cnt_reg <= '0;
        // An sclk edge coincident with the CS edge is address bit 0.
        if (sclk_rise) begin
          addr_reg    <= addr_shift;
          bit_cnt_reg <= CNT_WIDTH'(1);
        end
      end else if (!cs_rise) begin
        case (state_reg)
          ADDR: if (sclk_rise) begin
            if (last_addr_bit) begin
              addr_reg    <= addr_wrapped;
              bit_cnt_reg <= '0;
            end else begin
              addr_reg    <= addr_shift;
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
          end
          RW: if (sclk_rise) begin
            bit_cnt_reg <= '0;
            miso_reg    <= 1'b0;
            if (mosi_bit) rd_shift_reg <= rd_data_reg;
          end
          WDATA: if (sclk_rise) begin
            wdata_reg <= data_shift;
            if (last_data_bit) begin
              wr_en_reg   <= 1'b1;
              wr_addr_reg <= addr_reg;
              wr_data_reg <= data_shift;
              bit_cnt_reg <= '0;
              if (BURST != 0) begin
                addr_reg <= addr_inc;
                if (addr_at_end) wrap_reg <= 1'b1;
              end
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
          end
          RDATA: begin
            if (sclk_fall) begin
              miso_reg     <= rd_shift_reg[DATA_WIDTH-1];
              rd_shift_reg <= {rd_shift_reg[DATA_WIDTH-2:0], 1'b0};
            end else if (sclk_rise) begin
              if (last_data_bit) begin
                bit_cnt_reg <= '0;
                if (BURST != 0) begin
                  // rd_data_reg already holds the following word.
                  rd_shift_reg <= rd_data_reg;
                  addr_reg     <= addr_inc;
                  if (addr_at_end) wrap_reg <= 1'b1;
                end
              end else begin
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // During a read the port looks one word ahead so bursts have no gap.
  assign rd_addr = (state_reg == RDATA) ? addr_inc : addr_reg;

  always_ff @(posedge clk) begin
    if (wr_en_reg) mem[wr_addr_reg] <= wr_data_reg;
    rd_data_reg <= mem[rd_addr];
  end

endmodule

// File: tb/tb_spi_burst_memory.sv
`timescale 1ns / 1ps
// Bench for spi_burst_memory: three instances (default, single-word, DEPTH=100)
// driven by a bit-banged SPI master; read bytes are checked by a scoreboard.
module tb_spi_burst_memory;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic [2:0] cs = 3'b111;
  logic [2:0] miso;
  logic [3:0] leds [3];

  int total = 0;
  int bad = 0;
  int sel = 0;
  logic miso_s;
  logic [7:0] exp_q[$];
  logic [7:0] act_q[$];

  always #5 clk = ~clk;

  spi_burst_memory dut_a (
    .clk(clk), .reset(rst), .sclk(sclk), .cs_pin(cs[0]), .mosi_pin(mosi),
    .miso_pin(miso[0]), .leds(leds[0])
  );

  spi_burst_memory #(.BURST(0)) dut_b (
    .clk(clk), .reset(rst), .sclk(sclk), .cs_pin(cs[1]), .mosi_pin(mosi),
    .miso_pin(miso[1]), .leds(leds[1])
  );

  spi_burst_memory #(.DEPTH(100)) dut_c (
    .clk(clk), .reset(rst), .sclk(sclk), .cs_pin(cs[2]), .mosi_pin(mosi),
    .miso_pin(miso[2]), .leds(leds[2])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compares each byte the master captured against the queue.
  initial begin
    forever begin
      @(negedge clk);
      if (act_q.size() > 0) begin
        logic [7:0] a;
        a = act_q.pop_front();
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rd_unexpected: got %02h expected none", a);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          $display("read byte from dut %0d: got %02h expected %02h", sel, a, e);
          check("rd_byte", 32'(a), 32'(e));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic send_bit(input logic b);
    mosi = b;
    #80 sclk = 1'b1;
    miso_s = miso[sel];
    #80 sclk = 1'b0;
  endtask

  task automatic frame_start(input int s);
    sel = s;
    cs[s] = 1'b0;
    #100;
  endtask

  task automatic frame_end();
    #40 cs[sel] = 1'b1;
    #200;
  endtask

  task automatic send_addr(input logic [6:0] a, input logic rw);
    for (int i = 6; i >= 0; i--) send_bit(a[i]);
    send_bit(rw);
  endtask

  task automatic send_byte(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
  endtask

  task automatic recv_byte();
    logic [7:0] v;
    v = '0;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b0);
      v[i] = miso_s;
    end
    act_q.push_back(v);
  endtask

  task automatic write_word(input int s, input logic [6:0] a, input logic [7:0] d);
    frame_start(s);
    send_addr(a, 1'b0);
    send_byte(d);
    frame_end();
    $display("write dut %0d addr %02h data %02h", s, a, d);
  endtask

  task automatic read_word(input int s, input logic [6:0] a, input logic [7:0] e);
    exp_q.push_back(e);
    frame_start(s);
    send_addr(a, 1'b1);
    recv_byte();
    frame_end();
  endtask

  initial begin
    #23;
    for (int k = 0; k < 3; k++) begin
      check("rst_miso", 32'(miso[k]), 32'(0));
      check("rst_leds", 32'(leds[k]), 32'(0));
    end
    rst = 1'b0;
    #100;

    // Basic write/read on the default instance; leds[2] during write data.
    frame_start(0);
    send_addr(7'h55, 1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    #20 check("leds_wdata", 32'(leds[0]), 32'(4'b0101));
    for (int i = 5; i >= 0; i--) send_bit(i[0] ? 1'b1 : 1'b0);
    frame_end();
    check("leds_idle", 32'(leds[0]), 32'(4'b0000));
    exp_q.push_back(8'hAA);
    frame_start(0);
    send_addr(7'h55, 1'b1);
    #20 check("leds_rdata", 32'(leds[0]), 32'(4'b0011));
    recv_byte();
    frame_end();

    // Burst write across the top of memory, then burst read back.
    frame_start(0);
    send_addr(7'h7E, 1'b0);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    frame_end();
    $display("burst write dut 0 addr 7e data 11 22 33");
    check("leds_wrap_w", 32'(leds[0]), 32'(4'b1000));
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    frame_start(0);
    check("leds_wrap_clr", 32'(leds[0]), 32'(4'b0001));
    send_addr(7'h7E, 1'b1);
    recv_byte();
    recv_byte();
    recv_byte();
    frame_end();
    check("leds_wrap_r", 32'(leds[0]), 32'(4'b1000));

    // Aborted write after 5 data bits leaves memory intact.
    write_word(0, 7'h10, 8'h5A);
    frame_start(0);
    send_addr(7'h10, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    frame_end();
    check("leds_abort", 32'(leds[0]), 32'(4'b0000));
    read_word(0, 7'h10, 8'h5A);

    // Single-word instance: extra bits are ignored, miso stays 0 in HOLD.
    write_word(1, 7'h21, 8'hC3);
    frame_start(1);
    send_addr(7'h20, 1'b0);
    send_byte(8'h0F);
    #20 check("leds_hold", 32'(leds[1]), 32'(4'b0001));
    send_byte(8'hFF);
    frame_end();
    exp_q.push_back(8'h0F);
    exp_q.push_back(8'h00);
    frame_start(1);
    send_addr(7'h20, 1'b1);
    recv_byte();
    recv_byte();
    frame_end();
    read_word(1, 7'h21, 8'hC3);

    // DEPTH=100: address 105 wraps to 5.
    write_word(2, 7'd105, 8'h77);
    read_word(2, 7'd5, 8'h77);
    read_word(2, 7'd105, 8'h77);

    // Reset in the middle of a read: outputs drop at once, memory survives.
    frame_start(0);
    send_addr(7'h55, 1'b1);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    #40 check("miso_mid", 32'(miso[0]), 32'(1));
    check("leds_mid", 32'(leds[0]), 32'(4'b0011));
    rst = 1'b1;
    #1 check("miso_async_rst", 32'(miso[0]), 32'(0));
    check("leds_async_rst", 32'(leds[0]), 32'(4'b0000));
    #50 cs[0] = 1'b1;
    #50 rst = 1'b0;
    #200;
    read_word(0, 7'h55, 8'hAA);

    // CS already low at reset release: the frame must be ignored.
    cs[0] = 1'b0;
    rst = 1'b1;
    #50 rst = 1'b0;
    #200;
    sel = 0;
    send_addr(7'h55, 1'b0);
    send_byte(8'h00);
    #20 check("leds_no_arm", 32'(leds[0]), 32'(4'b0001));
    cs[0] = 1'b1;
    #200;
    read_word(0, 7'h55, 8'hAA);

    for (int i = 0; i < 100 && act_q.size() > 0; i++) @(negedge clk);
    check("sb_drain", 32'(act_q.size() + exp_q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
